// File: rtl/cmd_seq_if.sv
// cmd_seq_if: request handshake from the requester plus the registered
// command/address bundle that cmd_seq drives into the DDR5 packet generator.
// master = requester side, slave = cmd_seq side.
interface cmd_seq_if;
    // Request channel
    logic        req_valid;
    logic        req_wr;
    logic [2:0]  req_bg;
    logic        req_ba;
    logic [15:0] req_row;
    logic [9:0]  req_col;
    logic        req_ready;

    // Command/address bundle to the packet generator
    logic [3:0]  current_state;
    logic        CS;
    logic [2:0]  BG;
    logic        BA;
    logic [15:0] row;
    logic [9:0]  col;

    modport master (
        output req_valid, req_wr, req_bg, req_ba, req_row, req_col,
        input  req_ready, current_state, CS, BG, BA, row, col
    );

    modport slave (
        input  req_valid, req_wr, req_bg, req_ba, req_row, req_col,
        output req_ready, current_state, CS, BG, BA, row, col
    );
endinterface

// File: rtl/cmd_seq.sv
// cmd_seq: DDR5 command sequencer. Accepts one read/write request at a time,
// then issues ACT and CAS (two cycles each) separated by tRCD/tRP gaps that
// are timed with an 8-bit down-counter loaded on entry to each wait state.
//
// Optional feature macro: CMD_SEQ_ROW_HIT_EN
//   undefined : closed page, ACT -> RDA/WRA -> tRP for every request.
//   defined   : open page, one open-row register; hits go straight to CAS
//               (RD/WR), misses precharge first (PRE -> tRP -> ACT).
module cmd_seq #(
    parameter int unsigned T_RCD = 3,  // idle cycles between ACT and CAS, 1..255
    parameter int unsigned T_RP  = 4   // idle cycles after CAS/PRE, 1..255
) (
    input  logic     clk,
    input  logic     rst,
    cmd_seq_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT1,
        S_ACT2,
        S_WRCD,
        S_CAS1,
        S_CAS2,
        S_WRP
`ifdef CMD_SEQ_ROW_HIT_EN
        ,
        S_PRE1,
        S_PRE2
`endif
    } state_t;

    // Command codes understood by the packet generator
    localparam logic [3:0] C_IDLE = 4'd0;
    localparam logic [3:0] C_ACT  = 4'd8;
    localparam logic [3:0] C_RD   = 4'd4;
    localparam logic [3:0] C_WR   = 4'd7;
    localparam logic [3:0] C_RDA  = 4'd12;
    localparam logic [3:0] C_WRA  = 4'd5;
    localparam logic [3:0] C_PRE  = 4'd13;

    localparam logic [7:0] RCD_LOAD = 8'(T_RCD);
    localparam logic [7:0] RP_LOAD  = 8'(T_RP);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [2:0]  bg_q;
    logic        ba_q;
    logic [15:0] row_q;
    logic [9:0]  col_q;
    logic [3:0]  code_q;
    logic        cs_q;
    logic        accept;

`ifdef CMD_SEQ_ROW_HIT_EN
    // Open-row tracking: which bank/row was left open by the last ACT
    logic        orow_valid_q, orow_valid_d;
    logic [2:0]  orow_bg_q, orow_bg_d;
    logic        orow_ba_q, orow_ba_d;
    logic [15:0] orow_row_q, orow_row_d;
    logic        row_hit;
`endif

    assign accept = bus.req_valid && (state_q == S_IDLE);

    // Request type seen by the next-cycle output decode: on the accept edge
    // the new type must be used, since a row hit goes straight into CAS.
    assign wr_d = accept ? bus.req_wr : wr_q;

`ifdef CMD_SEQ_ROW_HIT_EN
    assign row_hit = orow_valid_q
                  && (orow_bg_q  == bus.req_bg)
                  && (orow_ba_q  == bus.req_ba)
                  && (orow_row_q == bus.req_row);
`endif

    // Command code driven while in a given state
    function automatic logic [3:0] code_of(input state_t s, input logic wr);
        logic [3:0] c;
        c = C_IDLE;
        case (s)
            S_ACT1, S_ACT2: c = C_ACT;
`ifdef CMD_SEQ_ROW_HIT_EN
            S_CAS1, S_CAS2: c = wr ? C_WR : C_RD;
            S_PRE1, S_PRE2: c = C_PRE;
`else
            S_CAS1, S_CAS2: c = wr ? C_WRA : C_RDA;
`endif
            default:        c = C_IDLE;
        endcase
        return c;
    endfunction

    // Chip select is asserted (low) only in the first cycle of a command
    function automatic logic cs_of(input state_t s);
        logic c;
        c = 1'b1;
        case (s)
            S_ACT1, S_CAS1: c = 1'b0;
`ifdef CMD_SEQ_ROW_HIT_EN
            S_PRE1:         c = 1'b0;
`endif
            default:        c = 1'b1;
        endcase
        return c;
    endfunction

    // Next-state, wait-counter and open-row update logic
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef CMD_SEQ_ROW_HIT_EN
        orow_valid_d = orow_valid_q;
        orow_bg_d    = orow_bg_q;
        orow_ba_d    = orow_ba_q;
        orow_row_d   = orow_row_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef CMD_SEQ_ROW_HIT_EN
                    if (row_hit)
                        state_d = S_CAS1;
                    else if (orow_valid_q)
                        state_d = S_PRE1;
                    else
                        state_d = S_ACT1;
`else
                    state_d = S_ACT1;
`endif
                end
            end
            S_ACT1: state_d = S_ACT2;
            S_ACT2: begin
                state_d = S_WRCD;
                cnt_d   = RCD_LOAD;
`ifdef CMD_SEQ_ROW_HIT_EN
                // The row named by the latched request is now open
                orow_valid_d = 1'b1;
                orow_bg_d    = bg_q;
                orow_ba_d    = ba_q;
                orow_row_d   = row_q;
`endif
            end
            S_WRCD: begin
                if (cnt_q <= 8'd1)
                    state_d = S_CAS1;
                else
                    cnt_d = cnt_q - 8'd1;
            end
            S_CAS1: state_d = S_CAS2;
            S_CAS2: begin
`ifdef CMD_SEQ_ROW_HIT_EN
                // Row stays open; no precharge after the column access
                state_d = S_IDLE;
`else
                state_d = S_WRP;
                cnt_d   = RP_LOAD;
`endif
            end
            S_WRP: begin
                if (cnt_q <= 8'd1) begin
`ifdef CMD_SEQ_ROW_HIT_EN
                    // Only a precharge leads here: open the requested row next
                    state_d = S_ACT1;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`ifdef CMD_SEQ_ROW_HIT_EN
            S_PRE1: state_d = S_PRE2;
            S_PRE2: begin
                state_d      = S_WRP;
                cnt_d        = RP_LOAD;
                orow_valid_d = 1'b0;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, latched request and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register, including the address latches and the
            // output codes, is reset so the packet generator sees a clean
            // IDLE/CS-high bundle the instant reset asserts.
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            wr_q    <= 1'b0;
            bg_q    <= 3'd0;
            ba_q    <= 1'b0;
            row_q   <= 16'd0;
            col_q   <= 10'd0;
            code_q  <= C_IDLE;
            cs_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            code_q  <= code_of(state_d, wr_d);
            cs_q    <= cs_of(state_d);
            if (accept) begin
                bg_q  <= bus.req_bg;
                ba_q  <= bus.req_ba;
                row_q <= bus.req_row;
                col_q <= bus.req_col;
            end
        end
    end

`ifdef CMD_SEQ_ROW_HIT_EN
    // Open-row register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orow_valid_q <= 1'b0;
            orow_bg_q    <= 3'd0;
            orow_ba_q    <= 1'b0;
            orow_row_q   <= 16'd0;
        end else begin
            orow_valid_q <= orow_valid_d;
            orow_bg_q    <= orow_bg_d;
            orow_ba_q    <= orow_ba_d;
            orow_row_q   <= orow_row_d;
        end
    end
`endif

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.current_state = code_q;
    assign bus.CS            = cs_q;
    assign bus.BG            = bg_q;
    assign bus.BA            = ba_q;
    assign bus.row           = row_q;
    assign bus.col           = col_q;

    // Chip select low always accompanies a real command code
    a_cs_has_cmd: assert property (@(posedge clk) disable iff (rst)
        !cs_q |-> (code_q != C_IDLE));

    // Wait states always hold a live count, so the counter never wraps
    a_wait_cnt_live: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_WRCD || state_q == S_WRP) |-> (cnt_q != 8'd0));

endmodule

// File: tb/tb_cmd_seq.sv
// tb_cmd_seq: table-driven self-checking bench for cmd_seq at the default
// timing (T_RCD=3, T_RP=4). Open-page sequences run when CMD_SEQ_ROW_HIT_EN
// is defined for the build.
module tb_cmd_seq;

    typedef struct packed {
        logic [2:0]  bg;
        logic        ba;
        logic [15:0] row;
        logic [9:0]  col;
    } fields_t;

    typedef struct {
        logic       valid;
        logic       wr;
        fields_t    f;
        logic [3:0] e_code;
        logic       e_cs;
        logic       e_ready;
        fields_t    e_f;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cmd_seq_if bus ();

    cmd_seq #(.T_RCD(3), .T_RP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    localparam fields_t ZERO = '0;
    localparam fields_t FA = '{bg: 3'd5, ba: 1'b1, row: 16'hA5C3, col: 10'h2F4};
    localparam fields_t FW = '{bg: 3'd3, ba: 1'b0, row: 16'h1234, col: 10'h155};
    localparam fields_t FR = '{bg: 3'd6, ba: 1'b1, row: 16'hBEEF, col: 10'h3AA};
    localparam fields_t FJ = '{bg: 3'd2, ba: 1'b0, row: 16'hFFFF, col: 10'h0C3};
    localparam fields_t FC = '{bg: 3'd7, ba: 1'b1, row: 16'hFFFF, col: 10'h3FF};
    localparam fields_t FD = '{bg: 3'd1, ba: 1'b0, row: 16'h0042, col: 10'h011};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wr, input fields_t f);
        bus.req_valid = v;
        bus.req_wr    = wr;
        bus.req_bg    = f.bg;
        bus.req_ba    = f.ba;
        bus.req_row   = f.row;
        bus.req_col   = f.col;
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic fields_t out_fields();
        fields_t f;
        f.bg  = bus.BG;
        f.ba  = bus.BA;
        f.row = bus.row;
        f.col = bus.col;
        return f;
    endfunction

    task automatic push(input logic v, input logic wr, input fields_t f,
                        input logic [3:0] e_code, input logic e_cs,
                        input logic e_ready, input fields_t e_f);
        vec_t t;
        t.valid = v;   t.wr = wr;     t.f = f;
        t.e_code = e_code; t.e_cs = e_cs; t.e_ready = e_ready; t.e_f = e_f;
        tbl.push_back(t);
    endtask

    // n idle-code cycles with CS high and req_ready low
    task automatic push_gap(input int n, input logic v, input logic wr,
                            input fields_t f, input fields_t e_f);
        for (int i = 0; i < n; i++)
            push(v, wr, f, 4'd0, 1'b1, 1'b0, e_f);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].valid, tbl[i].wr, tbl[i].f);
            tick();
            check($sformatf("%s[%0d].code", tag, i), 32'(bus.current_state), 32'(tbl[i].e_code));
            check($sformatf("%s[%0d].cs", tag, i), 32'(bus.CS), 32'(tbl[i].e_cs));
            check($sformatf("%s[%0d].ready", tag, i), 32'(bus.req_ready), 32'(tbl[i].e_ready));
            check($sformatf("%s[%0d].fields", tag, i), 32'(out_fields()), 32'(tbl[i].e_f));
        end
        tbl.delete();
    endtask

    // Bounded wait for the sequencer to return to idle
    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        drive(1'b0, 1'b0, ZERO);
        while (!bus.req_ready && n < budget) begin
            tick();
            n++;
        end
        check({tag, ".ready_timeout"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: hold 3 cycles, release away from the edge
        rst = 1'b1;
        drive(1'b0, 1'b0, ZERO);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset.code", 32'(bus.current_state), 32'd0);
        check("reset.cs", 32'(bus.CS), 32'd1);
        check("reset.fields", 32'(out_fields()), 32'(ZERO));
        check("reset.ready", 32'(bus.req_ready), 32'd1);
        tick();

`ifndef CMD_SEQ_ROW_HIT_EN
        // Closed-page read; junk on the inputs after accept must be ignored
        push(1'b1, 1'b0, FA, 4'd8, 1'b0, 1'b0, FA);
        push(1'b0, 1'b1, FJ, 4'd8, 1'b1, 1'b0, FA);
        push_gap(3, 1'b0, 1'b1, FJ, FA);
        push(1'b0, 1'b0, FJ, 4'd12, 1'b0, 1'b0, FA);
        push(1'b0, 1'b0, FJ, 4'd12, 1'b1, 1'b0, FA);
        push_gap(4, 1'b0, 1'b0, FJ, FA);
        push(1'b0, 1'b0, ZERO, 4'd0, 1'b1, 1'b1, FA);
        run_table("rd");

        // Write, then back-to-back read with req_valid held high: the second
        // accept lands on the 12th edge after the first
        push(1'b1, 1'b1, FW, 4'd8, 1'b0, 1'b0, FW);
        push(1'b1, 1'b0, FR, 4'd8, 1'b1, 1'b0, FW);
        push_gap(3, 1'b1, 1'b0, FR, FW);
        push(1'b1, 1'b0, FR, 4'd5, 1'b0, 1'b0, FW);
        push(1'b1, 1'b0, FR, 4'd5, 1'b1, 1'b0, FW);
        push_gap(4, 1'b1, 1'b0, FR, FW);
        push(1'b1, 1'b0, FR, 4'd0, 1'b1, 1'b1, FW);
        push(1'b1, 1'b0, FR, 4'd8, 1'b0, 1'b0, FR);
        push(1'b0, 1'b1, FJ, 4'd8, 1'b1, 1'b0, FR);
        push_gap(3, 1'b0, 1'b1, FJ, FR);
        push(1'b0, 1'b1, FJ, 4'd12, 1'b0, 1'b0, FR);
        push(1'b0, 1'b1, FJ, 4'd12, 1'b1, 1'b0, FR);
        push_gap(4, 1'b0, 1'b1, FJ, FR);
        push(1'b0, 1'b0, ZERO, 4'd0, 1'b1, 1'b1, FR);
        run_table("wr_rd");
`endif

        // Reset in the tRCD wait: outputs clear without a clock edge
        drive(1'b1, 1'b0, FC);
        tick();
        check("mid.act", 32'(bus.current_state), 32'd8);
        drive(1'b0, 1'b0, ZERO);
        tick();
        tick();
        check("mid.wrcd", 32'(bus.current_state), 32'd0);
        check("mid.wrcd_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid.rst_code", 32'(bus.current_state), 32'd0);
        check("mid.rst_cs", 32'(bus.CS), 32'd1);
        check("mid.rst_fields", 32'(out_fields()), 32'(ZERO));
        check("mid.rst_ready", 32'(bus.req_ready), 32'd1);
        // No accept while reset is held, even with a valid request
        drive(1'b1, 1'b1, FD);
        tick();
        check("mid.no_accept_code", 32'(bus.current_state), 32'd0);
        check("mid.no_accept_fields", 32'(out_fields()), 32'(ZERO));
        rst = 1'b0;
        #1;
        drive(1'b1, 1'b1, FD);
        tick();
        check("mid.restart_code", 32'(bus.current_state), 32'd8);
        check("mid.restart_cs", 32'(bus.CS), 32'd0);
        check("mid.restart_fields", 32'(out_fields()), 32'(FD));
        wait_ready("mid", 40);

`ifdef CMD_SEQ_ROW_HIT_EN
        // Open page: first read on row 0x0010 has no open row -> ACT
        push(1'b1, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h001},
             4'd8, 1'b0, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h001});
        wait_ready("pre_open", 40);
        rst = 1'b1; #1; rst = 1'b0; #1;
        push(1'b0, 1'b0, ZERO, 4'd8, 1'b1, 1'b0, ZERO);
        tbl.delete();
        push(1'b1, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h001},
             4'd8, 1'b0, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h001});
        push(1'b0, 1'b0, ZERO, 4'd8, 1'b1, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h001});
        push_gap(3, 1'b0, 1'b0, ZERO, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h001});
        push(1'b0, 1'b0, ZERO, 4'd4, 1'b0, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h001});
        push(1'b0, 1'b0, ZERO, 4'd4, 1'b1, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h001});
        push(1'b0, 1'b0, ZERO, 4'd0, 1'b1, 1'b1, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h001});
        // Same bank/row: hit, CAS one cycle after accept
        push(1'b1, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h002},
             4'd4, 1'b0, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h002});
        push(1'b0, 1'b0, ZERO, 4'd4, 1'b1, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h002});
        push(1'b0, 1'b0, ZERO, 4'd0, 1'b1, 1'b1, '{bg: 3'd2, ba: 1'b1, row: 16'h0010, col: 10'h002});
        // Row 0x0011: miss -> PRE, tRP, ACT, tRCD, RD
        push(1'b1, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0011, col: 10'h003},
             4'd13, 1'b0, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0011, col: 10'h003});
        push(1'b0, 1'b0, ZERO, 4'd13, 1'b1, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0011, col: 10'h003});
        push_gap(4, 1'b0, 1'b0, ZERO, '{bg: 3'd2, ba: 1'b1, row: 16'h0011, col: 10'h003});
        push(1'b0, 1'b0, ZERO, 4'd8, 1'b0, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0011, col: 10'h003});
        push(1'b0, 1'b0, ZERO, 4'd8, 1'b1, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0011, col: 10'h003});
        push_gap(3, 1'b0, 1'b0, ZERO, '{bg: 3'd2, ba: 1'b1, row: 16'h0011, col: 10'h003});
        push(1'b0, 1'b0, ZERO, 4'd4, 1'b0, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0011, col: 10'h003});
        push(1'b0, 1'b0, ZERO, 4'd4, 1'b1, 1'b0, '{bg: 3'd2, ba: 1'b1, row: 16'h0011, col: 10'h003});
        push(1'b0, 1'b0, ZERO, 4'd0, 1'b1, 1'b1, '{bg: 3'd2, ba: 1'b1, row: 16'h0011, col: 10'h003});
        run_table("open");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
